control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multicycle sequencer that drives the 64-bit datapath control word and owns the PC.
//  Fetches a 32-bit word from instruction memory and latches it in IR.
//  Decodes it and sequences FETCH/EXEC/MEM so the datapath performs ALU, load/store and branch ops.
//  Consumes datapath status {v,c,n,z,z_imm} for conditional branches.
// PARAMETERS
//  RESET_PC  64'h0     PC value loaded on reset
//  FS_ADD    5'b00100  alu fs code for add
//  FS_SUB    5'b00101  alu fs code for subtract (issued with c0=1)
//  FS_AND    5'b00000  alu fs code for bitwise and
//  FS_ORR    5'b00001  alu fs code for bitwise or
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   async reset, active-low
//  instr     in   32  instruction memory data at address pc (combinational)
//  stall     in   1   hold in FETCH while high (imem not ready)
//  status    in   5   datapath status {v,c,n,z,z_imm}
//  pc        out  64  program counter / instruction memory address
//  k         out  64  constant to datapath b mux
//  reg_addr, a_addr, b_addr  out 5 each  register file addresses
//  fs        out  5   alu function select
//  reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en, c0  out 1 each
//                     datapath control word bits
//  halted    out  1   FSM in HALT
//  illegal   out  1   HALT was entered on an undefined opcode
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH, pc=RESET_PC, IR=0, halted=0, illegal=0; all control outputs 0.
//  Control outputs are combinational from state+IR; every field not listed below is 0.
//  Fields: op=IR[31:26], rd=IR[4:0], rn=IR[9:5], rm=IR[20:16], imm12=IR[21:10], imm9=IR[20:12],
//          imm26=IR[25:0], imm19=IR[23:5], cond=IR[3:0].
//  FETCH: if stall, hold; else IR<=instr, go EXEC. All control outputs 0.
//  EXEC by op (pc<=pc+4 on leaving EXEC unless noted):
//   00 NOP.
//   01 ADD/02 SUB/03 AND/04 ORR Rd=Rn op Rm: a_addr=rn, b_addr=rm, b_sel=0, alu_en=1, reg_w=1, reg_addr=rd.
//   05 ADDS/06 SUBS: as ADD/SUB plus stat_en=1.
//   08 ADDI/09 SUBI: as ADD/SUB but b_sel=1, k=zext(imm12).
//   SUB, SUBS, SUBI: fs=FS_SUB, c0=1. All other ALU ops: c0=0.
//   0A LDUR/0B STUR: a_addr=rn, b_sel=1, k=sext(imm9), fs=FS_ADD, alu_en=1, mem_en=1; go MEM, pc unchanged.
//   0C B: pc<=pc+(sext(imm26)<<2).
//   0D CBZ/0E CBNZ: a_addr=rd, b_sel=1, k=0, fs=FS_ADD. Taken if status[0]==1 (CBZ) or ==0 (CBNZ).
//    Taken: pc<=pc+(sext(imm19)<<2). Else pc+4.
//   0F B.cond: flags {v,c,n,z}=status[4:1]; taken -> pc+(sext(imm19)<<2), else pc+4.
//    cond 0 EQ z; 1 NE !z; 2 HS c; 3 LO !c; 4 MI n; 5 PL !n; 6 VS v; 7 VC !v; 8 GE n==v; 9 LT n!=v.
//    cond 10..15: never taken.
//   3F HALT: go HALT, pc unchanged.
//   Any other op: go HALT, illegal<=1.
//   Next state is FETCH unless stated otherwise.
//  MEM (1 cycle, then FETCH, pc<=pc+4):
//   LDUR: chip_sel=1, mem_r=1, reg_w=1, reg_addr=rd.
//   STUR: b_addr=rd, b_en=1, mem_w=1.
//  HALT: absorbing, all control 0, halted=1; only reset exits.
//  Latency: ALU/branch/NOP 2 cycles; LDUR/STUR 3 cycles.
//  Never assert more than one of b_en/alu_en/chip_sel in any cycle (d bus contention).
//  Arithmetic: pc math is 64-bit modulo 2^64 (wraps silently). Offsets are relative to the branch's own pc.
//  stall: sampled only in FETCH; ignored in EXEC/MEM.
//  Reset mid-instruction: abort immediately to reset values. No partial write completes after rst falls.
// TESTING
//  1. Reset, instr=ADDI rd=1 rn=31 imm12=5 -> EXEC: k=5, b_sel=1, alu_en=1, reg_w=1, reg_addr=1; pc=4 after.
//  2. LDUR rd=2 rn=1 imm9=-8 -> EXEC: k=64'hFFFF_FFFF_FFFF_FFF8, mem_en=1;
//     MEM: chip_sel=1, mem_r=1, reg_w=1, reg_addr=2; pc+4 after 3 cycles.
//  3. CBZ imm19=-2 at pc=0x40: status[0]=1 -> pc=0x38; status[0]=0 -> pc=0x44.
//  4. B.cond GE with status={v=1,c,n=1,z}=5'b1x1x_x -> taken. LT same flags -> pc+4. cond 12 -> pc+4.
//  5. stall=1 for 3 cycles in FETCH -> state/pc/IR held, outputs 0. Then SUBS -> fs=FS_SUB, c0=1, stat_en=1.
//  6. op=6'h20 -> HALT, illegal=1, pc frozen. rst=0 during LDUR MEM cycle -> mem_r/reg_w drop at once, pc=RESET_PC.

Source files
------------

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle FETCH/EXEC/MEM sequencer driving the datapath control word and PC
module control_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [4:0]  FS_ADD   = 5'b00100,
  parameter logic [4:0]  FS_SUB   = 5'b00101,
  parameter logic [4:0]  FS_AND   = 5'b00000,
  parameter logic [4:0]  FS_ORR   = 5'b00001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic [4:0]  status,
  output logic [63:0] pc,
  output logic [63:0] k,
  output logic [4:0]  reg_addr,
  output logic [4:0]  a_addr,
  output logic [4:0]  b_addr,
  output logic [4:0]  fs,
  output logic        reg_w,
  output logic        b_sel,
  output logic        b_en,
  output logic        alu_en,
  output logic        mem_en,
  output logic        chip_sel,
  output logic        mem_w,
  output logic        mem_r,
  output logic        stat_en,
  output logic        c0,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_AND   = 6'h03;
  localparam logic [5:0] OP_ORR   = 6'h04;
  localparam logic [5:0] OP_ADDS  = 6'h05;
  localparam logic [5:0] OP_SUBS  = 6'h06;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h09;
  localparam logic [5:0] OP_LDUR  = 6'h0A;
  localparam logic [5:0] OP_STUR  = 6'h0B;
  localparam logic [5:0] OP_B     = 6'h0C;
  localparam logic [5:0] OP_CBZ   = 6'h0D;
  localparam logic [5:0] OP_CBNZ  = 6'h0E;
  localparam logic [5:0] OP_BCOND = 6'h0F;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  state_t      state;
  logic [31:0] ir;

  logic [5:0]  op;
  logic [4:0]  rd, rn, rm;
  logic [11:0] imm12;
  logic [8:0]  imm9;
  logic [25:0] imm26;
  logic [18:0] imm19;
  logic [3:0]  cond;

  assign op    = ir[31:26];
  assign rd    = ir[4:0];
  assign rn    = ir[9:5];
  assign rm    = ir[20:16];
  assign imm12 = ir[21:10];
  assign imm9  = ir[20:12];
  assign imm26 = ir[25:0];
  assign imm19 = ir[23:5];
  assign cond  = ir[3:0];

  logic [63:0] pc_plus4, pc_br26, pc_br19;
  assign pc_plus4 = pc + 64'd4;
  assign pc_br26  = pc + {{36{imm26[25]}}, imm26, 2'b00};
  assign pc_br19  = pc + {{43{imm19[18]}}, imm19, 2'b00};

  logic flag_v, flag_c, flag_n, flag_z;
  assign flag_v = status[4];
  assign flag_c = status[3];
  assign flag_n = status[2];
  assign flag_z = status[1];

  // Condition evaluation for B.cond; codes 10..15 are reserved and never branch
  logic cond_taken;
  always_comb begin
    cond_taken = 1'b0;
    case (cond)
      4'd0:    cond_taken = flag_z;
      4'd1:    cond_taken = !flag_z;
      4'd2:    cond_taken = flag_c;
      4'd3:    cond_taken = !flag_c;
      4'd4:    cond_taken = flag_n;
      4'd5:    cond_taken = !flag_n;
      4'd6:    cond_taken = flag_v;
      4'd7:    cond_taken = !flag_v;
      4'd8:    cond_taken = (flag_n == flag_v);
      4'd9:    cond_taken = (flag_n != flag_v);
      default: cond_taken = 1'b0;
    endcase
  end

  // Sequencer: state, IR, PC and sticky halt/illegal flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!stall) begin
            ir    <= instr;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS,
            OP_ADDI, OP_SUBI: begin
              pc    <= pc_plus4;
              state <= S_FETCH;
            end
            OP_LDUR, OP_STUR: state <= S_MEM;
            OP_B: begin
              pc    <= pc_br26;
              state <= S_FETCH;
            end
            OP_CBZ: begin
              pc    <= status[0] ? pc_br19 : pc_plus4;
              state <= S_FETCH;
            end
            OP_CBNZ: begin
              pc    <= !status[0] ? pc_br19 : pc_plus4;
              state <= S_FETCH;
            end
            OP_BCOND: begin
              pc    <= cond_taken ? pc_br19 : pc_plus4;
              state <= S_FETCH;
            end
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: begin
              state   <= S_HALT;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          pc    <= pc_plus4;
          state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
      endcase
    end
  end

  // Control word decode from state and IR; the d-bus drivers (b_en/alu_en/chip_sel) are one-hot per phase
  always_comb begin
    k        = '0;
    reg_addr = '0;
    a_addr   = '0;
    b_addr   = '0;
    fs       = '0;
    reg_w    = 1'b0;
    b_sel    = 1'b0;
    b_en     = 1'b0;
    alu_en   = 1'b0;
    mem_en   = 1'b0;
    chip_sel = 1'b0;
    mem_w    = 1'b0;
    mem_r    = 1'b0;
    stat_en  = 1'b0;
    c0       = 1'b0;
    case (state)
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS, OP_ADDI, OP_SUBI: begin
            a_addr   = rn;
            b_addr   = rm;
            alu_en   = 1'b1;
            reg_w    = 1'b1;
            reg_addr = rd;
            stat_en  = (op == OP_ADDS) || (op == OP_SUBS);
            if ((op == OP_ADDI) || (op == OP_SUBI)) begin
              b_sel = 1'b1;
              k     = {52'b0, imm12};
            end
            case (op)
              OP_SUB, OP_SUBS, OP_SUBI: begin
                fs = FS_SUB;
                c0 = 1'b1;
              end
              OP_AND:  fs = FS_AND;
              OP_ORR:  fs = FS_ORR;
              default: fs = FS_ADD;
            endcase
          end
          OP_LDUR, OP_STUR: begin
            a_addr = rn;
            b_sel  = 1'b1;
            k      = {{55{imm9[8]}}, imm9};
            fs     = FS_ADD;
            alu_en = 1'b1;
            mem_en = 1'b1;
          end
          OP_CBZ, OP_CBNZ: begin
            a_addr = rd;
            b_sel  = 1'b1;
            fs     = FS_ADD;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (op == OP_LDUR) begin
          chip_sel = 1'b1;
          mem_r    = 1'b1;
          reg_w    = 1'b1;
          reg_addr = rd;
        end else begin
          b_addr = rd;
          b_en   = 1'b1;
          mem_w  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against an instruction-level model
module tb_control_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [4:0]  FS_ADD   = 5'b00100;
  localparam logic [4:0]  FS_SUB   = 5'b00101;
  localparam logic [4:0]  FS_AND   = 5'b00000;
  localparam logic [4:0]  FS_ORR   = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        stall = 1'b0;
  logic [4:0]  status = '0;
  logic [63:0] pc, k;
  logic [4:0]  reg_addr, a_addr, b_addr, fs;
  logic        reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en, c0;
  logic        halted, illegal;

  control_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .stall(stall), .status(status),
    .pc(pc), .k(k), .reg_addr(reg_addr), .a_addr(a_addr), .b_addr(b_addr), .fs(fs),
    .reg_w(reg_w), .b_sel(b_sel), .b_en(b_en), .alu_en(alu_en), .mem_en(mem_en),
    .chip_sel(chip_sel), .mem_w(mem_w), .mem_r(mem_r), .stat_en(stat_en), .c0(c0),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [93:0] obs;
  assign obs = {k, reg_addr, a_addr, b_addr, fs, reg_w, b_sel, b_en, alu_en,
                mem_en, chip_sel, mem_w, mem_r, stat_en, c0};

  int checks = 0;
  int failures = 0;
  logic [63:0] mpc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sext_field(input longint val, input int bits);
    longint v;
    v = val;
    if (v >= (longint'(1) <<< (bits - 1))) v = v - (longint'(1) <<< bits);
    return 64'(v);
  endfunction

  // Expected control word for one phase (1 = execute, 2 = memory) of an instruction
  function automatic logic [93:0] exp_word(input int phase, input logic [31:0] ins);
    logic [5:0]  op;
    logic [63:0] ek;
    logic [4:0]  era, ea, eb, efs;
    logic        erw, ebs, ebe, ealu, emem, echip, emw, emr, estat, ec0;
    int          o;
    op = ins[31:26];
    o  = int'(op);
    ek = '0; era = '0; ea = '0; eb = '0; efs = '0;
    erw = 0; ebs = 0; ebe = 0; ealu = 0; emem = 0; echip = 0; emw = 0; emr = 0; estat = 0; ec0 = 0;
    if (phase == 1) begin
      if ((o >= 1 && o <= 6) || o == 8 || o == 9) begin
        ea = ins[9:5]; eb = ins[20:16]; ealu = 1; erw = 1; era = ins[4:0];
        ec0 = (o == 2 || o == 6 || o == 9);
        estat = (o == 5 || o == 6);
        if (ec0) efs = FS_SUB;
        else if (o == 3) efs = FS_AND;
        else if (o == 4) efs = FS_ORR;
        else efs = FS_ADD;
        if (o >= 8) begin
          ebs = 1;
          ek = 64'(ins[21:10]);
        end
      end else if (o == 10 || o == 11) begin
        ea = ins[9:5]; ebs = 1; ek = sext_field(longint'(ins[20:12]), 9);
        efs = FS_ADD; ealu = 1; emem = 1;
      end else if (o == 13 || o == 14) begin
        ea = ins[4:0]; ebs = 1; efs = FS_ADD;
      end
    end else if (phase == 2) begin
      if (o == 10) begin
        echip = 1; emr = 1; erw = 1; era = ins[4:0];
      end else if (o == 11) begin
        eb = ins[4:0]; ebe = 1; emw = 1;
      end
    end
    return {ek, era, ea, eb, efs, erw, ebs, ebe, ealu, emem, echip, emw, emr, estat, ec0};
  endfunction

  function automatic bit bcond_taken(input logic [3:0] cnd, input logic [4:0] st);
    bit v, c, n, z;
    v = st[4]; c = st[3]; n = st[2]; z = st[1];
    case (int'(cnd))
      0: return z;
      1: return !z;
      2: return c;
      3: return !c;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return n == v;
      9: return n != v;
      default: return 0;
    endcase
  endfunction

  // PC after the instruction completes (for non-halting instructions)
  function automatic logic [63:0] exp_next_pc(input logic [63:0] p, input logic [31:0] ins,
                                              input logic [4:0] st);
    int o;
    bit taken;
    o = int'(ins[31:26]);
    if (o == 12) return p + sext_field(longint'(ins[25:0]), 26) * 64'd4;
    taken = (o == 13 && st[0]) || (o == 14 && !st[0]) || (o == 15 && bcond_taken(ins[3:0], st));
    if (taken) return p + sext_field(longint'(ins[23:5]), 19) * 64'd4;
    return p + 64'd4;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    int o;
    o = int'(op);
    return (o <= 6) || (o >= 8 && o <= 15) || (o == 63);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_pc", pc, RESET_PC);
    check("rst_ctrl", obs, '0);
    check("rst_flags", {halted, illegal}, 2'b00);
    tick();
    rst = 1'b1;
    mpc = RESET_PC;
  endtask

  // One instruction from FETCH to completion; abort_mem pulls reset during the MEM cycle
  task automatic run_instr(input logic [31:0] ins, input int nstall, input logic [4:0] st,
                           input bit abort_mem);
    logic [5:0]  op;
    logic [63:0] npc;
    int          drv;
    op = ins[31:26];
    for (int i = 0; i <= nstall; i++) begin
      stall  = (i < nstall);
      instr  = (i < nstall) ? $urandom : ins;
      status = 5'($urandom);
      check("fetch_ctrl", obs, '0);
      check("fetch_pc", pc, mpc);
      tick();
    end
    stall  = 1'($urandom);
    instr  = $urandom;
    status = st;
    check("exec_ctrl", obs, exp_word(1, ins));
    check("exec_pc", pc, mpc);
    check("exec_halted", halted, 1'b0);
    drv = int'(b_en) + int'(alu_en) + int'(chip_sel);
    check("exec_dbus", drv <= 1, 1'b1);
    tick();
    status = 5'($urandom);
    if (op == 6'h0A || op == 6'h0B) begin
      check("mem_ctrl", obs, exp_word(2, ins));
      check("mem_pc", pc, mpc);
      drv = int'(b_en) + int'(alu_en) + int'(chip_sel);
      check("mem_dbus", drv <= 1, 1'b1);
      if (abort_mem) begin
        rst = 1'b0;
        #1;
        check("abort_mem_r", {mem_r, reg_w, chip_sel}, 3'b000);
        check("abort_pc", pc, RESET_PC);
        tick();
        rst = 1'b1;
        mpc = RESET_PC;
        return;
      end
      tick();
    end
    if (!is_legal(op) || op == 6'h3F) begin
      for (int j = 0; j < 2; j++) begin
        check("halt_flags", {halted, illegal}, {1'b1, !is_legal(op)});
        check("halt_pc", pc, mpc);
        check("halt_ctrl", obs, '0);
        tick();
      end
      do_reset();
    end else begin
      npc = exp_next_pc(mpc, ins, st);
      check("next_pc", pc, npc);
      mpc = npc;
    end
  endtask

  logic [5:0] legal_ops [15] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h08,
                                  6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

  initial begin
    logic [31:0] ins;
    int r;
    rst = 1'b0;
    mpc = RESET_PC;
    #2;
    check("init_pc", pc, RESET_PC);
    check("init_ctrl", obs, '0);
    check("init_flags", {halted, illegal}, 2'b00);
    tick();
    rst = 1'b1;

    // ADDI rd=1 rn=31 imm12=5
    run_instr({6'h08, 4'b0, 12'd5, 5'd31, 5'd1}, 0, 5'b0, 0);
    check("addi_pc4", pc, 64'h4);
    // LDUR rd=2 rn=1 imm9=-8
    run_instr({6'h0A, 5'b0, 9'h1F8, 2'b0, 5'd1, 5'd2}, 0, 5'b0, 0);
    check("ldur_pc", pc, 64'h8);
    // B to 0x40, CBZ -2 taken -> 0x38, B to 0x40, CBZ not taken -> 0x44
    run_instr({6'h0C, 26'd14}, 0, 5'b0, 0);
    check("b_pc", pc, 64'h40);
    run_instr({6'h0D, 2'b0, 19'h7FFFE, 5'd3}, 1, 5'b00001, 0);
    check("cbz_taken", pc, 64'h38);
    run_instr({6'h0C, 26'd2}, 0, 5'b0, 0);
    run_instr({6'h0D, 2'b0, 19'h7FFFE, 5'd3}, 0, 5'b00000, 0);
    check("cbz_not_taken", pc, 64'h44);
    // B.cond GE taken, LT not taken, cond 12 never
    run_instr({6'h0F, 2'b0, 19'd4, 1'b0, 4'd8}, 0, 5'b10100, 0);
    check("bge_taken", pc, 64'h54);
    run_instr({6'h0F, 2'b0, 19'd4, 1'b0, 4'd9}, 0, 5'b10100, 0);
    check("blt_not", pc, 64'h58);
    run_instr({6'h0F, 2'b0, 19'd4, 1'b0, 4'd12}, 0, 5'b11111, 0);
    check("bcond12_not", pc, 64'h5C);
    // Three stall cycles then SUBS
    run_instr({6'h06, 5'b0, 5'd7, 6'b0, 5'd4, 5'd9}, 3, 5'b0, 0);
    check("subs_pc", pc, 64'h60);
    // Undefined opcode halts with illegal set
    run_instr({6'h20, 26'h155}, 0, 5'b0, 0);
    // HALT opcode halts without illegal
    run_instr({6'h3F, 26'h0}, 0, 5'b0, 0);
    // Reset during LDUR MEM cycle
    run_instr({6'h0A, 26'h3FF_FFFF}, 0, 5'b0, 1);
    check("after_abort_pc", pc, RESET_PC);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      r = $urandom_range(0, 99);
      if (r < 94) ins[31:26] = legal_ops[$urandom_range(0, 14)];
      else if (r < 97) ins[31:26] = 6'h3F;
      ins = (r >= 97) ? {6'h10 + 6'($urandom_range(0, 46)), ins[25:0]} : ins;
      if (r >= 97 && ins[31:26] == 6'h3F) ins[31:26] = 6'h07;
      run_instr(ins, $urandom_range(0, 2), 5'($urandom), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
